// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU datapath and a word-organized data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extended.
//
// state | meaning
// IDLE  | ready for a request, memory address held
// RD    | read address presented to memory
// CAP   | read data available, extended load result captured
// MRG   | read data available, store lane merged into write word
// WR    | write-enable asserted for one cycle
// RESP  | one-cycle completion pulse
module mem_access_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W+1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_we2,
    input  logic [DATA_W-1:0] i_mem_read_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_MRG  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_err;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

    assign w_err = (i_req_size == 2'b11) ||
                   (i_req_size == 2'b01 && i_req_addr[0]) ||
                   (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00);

    always_comb begin
        w_byte = i_mem_read_data[7:0];
        case (r_lane)
            2'd1:    w_byte = i_mem_read_data[15:8];
            2'd2:    w_byte = i_mem_read_data[23:16];
            2'd3:    w_byte = i_mem_read_data[31:24];
            default: w_byte = i_mem_read_data[7:0];
        endcase
        w_half = r_lane[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = i_mem_read_data;
        endcase
    end

    // Only the addressed lane is replaced; the rest comes from the word just read.
    always_comb begin
        w_merged = i_mem_read_data;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                2'd3:    w_merged[31:24] = r_wdata[7:0];
                default: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_size == 2'b01) begin
            if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we       <= i_req_we;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_lane     <= i_req_addr[1:0];
                        r_addr     <= i_req_addr[ADDR_W+1:2];
                        r_wdata    <= i_req_wdata;
                        if (w_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else if (i_req_we && i_req_size == 2'b10) begin
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD:  r_state <= r_we ? S_MRG : S_CAP;
                S_CAP: begin
                    r_rdata <= w_load;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_MRG: begin
                    r_wdata <= w_merged;
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready      = (r_state == S_IDLE);
    assign o_resp_valid     = (r_state == S_RESP);
    assign o_resp_rdata     = r_rdata;
    assign o_resp_err       = r_err;
    assign o_mem_address    = r_addr;
    assign o_mem_write_data = r_wdata;
    assign o_mem_we2        = (r_state == S_WR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, handshake and reset
// sequences, then random requests against a byte-lane reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err, mem_we2;
    logic [31:0] resp_rdata, mem_write_data, mem_read_data;
    logic [5:0]  mem_address;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(6), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_mem_address(mem_address), .o_mem_write_data(mem_write_data),
        .o_mem_we2(mem_we2), .i_mem_read_data(mem_read_data)
    );

    // Registered-read memory; the preload port lets the bench seed words.
    always @(posedge clk) begin
        if (pre_en)       mem[pre_idx] <= pre_val;
        else if (mem_we2) mem[mem_address] <= mem_write_data;
        else              mem_read_data <= mem[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference: byte-lane arithmetic on a shadow memory.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [7:0] addr, input logic [31:0] wd,
                              output logic err, output logic [31:0] rd, output int lat);
        int nbytes, off, sh;
        logic [31:0] mask, v;
        nbytes = 1 << size;
        off = int'(addr % 4);
        err = (size == 2'd3) || (off % nbytes != 0);
        rd = 32'h0;
        if (err) begin
            lat = 1;
            return;
        end
        sh = 8 * off;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
        if (we) begin
            ref_mem[addr / 4] = (ref_mem[addr / 4] & ~(mask << sh)) | ((wd & mask) << sh);
            lat = (nbytes == 4) ? 2 : 4;
        end else begin
            v = (ref_mem[addr / 4] >> sh) & mask;
            if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
            rd = v;
            lat = 3;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [7:0] addr, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int we_cnt, output int we_cyc, output logic [5:0] we_addr);
        int g;
        lat = 0; err = 1'bx; rd = 'x; we_cnt = 0; we_cyc = 0; we_addr = '0;
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_we = $urandom; req_addr = $urandom; req_wdata = $urandom; req_size = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we2) begin
                we_cnt++; we_cyc = c; we_addr = mem_address;
            end
            if (resp_valid) begin
                lat = c; err = resp_err; rd = resp_rdata;
                break;
            end
        end
    endtask

    typedef struct {
        logic        pre;
        logic [31:0] pre_val;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[12];

    task automatic check_op(input string tag, input logic we, input logic [1:0] size,
                            input logic [7:0] addr, input int exp_lat, input logic exp_err,
                            input logic [31:0] exp_rd, input int lat, input logic err,
                            input logic [31:0] rd, input int we_cnt, input int we_cyc,
                            input logic [5:0] we_addr);
        logic st;
        st = we && !exp_err;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_we_cnt"}, we_cnt, st ? 1 : 0);
        if (st) begin
            chk({tag, "_we_cyc"}, we_cyc, exp_lat - 1);
            chk({tag, "_we_addr"}, {26'h0, we_addr}, {26'h0, addr[7:2]});
        end
    endtask

    initial begin
        int lat, we_cnt, we_cyc, r_lat;
        logic err, r_err, we, uns;
        logic [1:0] size;
        logic [7:0] addr;
        logic [31:0] rd, r_rd, wd;
        logic [5:0] we_addr;

        vecs[0]  = '{1, 32'h0,        1, 2'd2, 0, 8'h08, 32'hDEADBEEF, 0, 32'h0,        2, 32'hDEADBEEF};
        vecs[1]  = '{0, 32'h0,        0, 2'd2, 0, 8'h08, 32'h0,        0, 32'hDEADBEEF, 3, 32'hDEADBEEF};
        vecs[2]  = '{1, 32'h11223344, 1, 2'd0, 0, 8'h09, 32'hFFFFFFAA, 0, 32'h0,        4, 32'h1122AA44};
        vecs[3]  = '{0, 32'h0,        1, 2'd1, 0, 8'h0A, 32'h12345566, 0, 32'h0,        4, 32'h5566AA44};
        vecs[4]  = '{0, 32'h0,        0, 2'd2, 1, 8'h08, 32'h0,        0, 32'h5566AA44, 3, 32'h5566AA44};
        vecs[5]  = '{1, 32'h80FF7F01, 0, 2'd0, 0, 8'h0B, 32'h0,        0, 32'hFFFFFF80, 3, 32'h80FF7F01};
        vecs[6]  = '{0, 32'h0,        0, 2'd0, 1, 8'h0B, 32'h0,        0, 32'h00000080, 3, 32'h80FF7F01};
        vecs[7]  = '{0, 32'h0,        0, 2'd1, 0, 8'h08, 32'h0,        0, 32'h00007F01, 3, 32'h80FF7F01};
        vecs[8]  = '{0, 32'h0,        0, 2'd1, 0, 8'h0A, 32'h0,        0, 32'hFFFF80FF, 3, 32'h80FF7F01};
        vecs[9]  = '{0, 32'h0,        0, 2'd2, 0, 8'h09, 32'h0,        1, 32'h0,        1, 32'h80FF7F01};
        vecs[10] = '{1, 32'h0BADF00D, 0, 2'd1, 0, 8'h03, 32'h0,        1, 32'h0,        1, 32'h0BADF00D};
        vecs[11] = '{0, 32'h0,        1, 2'd3, 0, 8'h00, 32'hCAFEF00D, 1, 32'h0,        1, 32'h0BADF00D};

        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        rst_n = 1'b0;
        #3;
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_address", {26'h0, mem_address}, 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        chk("rst_we", {31'h0, mem_we2}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 64; i++) preload(6'(i), 32'hA5A5A5A5 ^ (32'h01010101 * i));

        foreach (vecs[i]) begin
            if (vecs[i].pre) preload(vecs[i].addr[7:2], vecs[i].pre_val);
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   lat, err, rd, we_cnt, we_cyc, we_addr);
            ref_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                       r_err, r_rd, r_lat);
            check_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr,
                     vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_rdata,
                     lat, err, rd, we_cnt, we_cyc, we_addr);
            chk($sformatf("vec%0d_word", i), mem[vecs[i].addr[7:2]], vecs[i].exp_word);
        end

        // Back-to-back word stores with valid held high.
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 8'h10; req_wdata = 32'h600DF00D;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("hs_ready_c%0d", c), {31'h0, req_ready}, (c % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("hs_resp_c%0d", c), {31'h0, resp_valid}, (c % 3 == 2) ? 32'h1 : 32'h0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ref_mem[4] = 32'h600DF00D;
        chk("hs_word", mem[4], 32'h600DF00D);

        // Reset during MRG of a byte store.
        preload(6'd2, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 8'h09; req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_we_rd", {31'h0, mem_we2}, 32'h0);
        @(negedge clk);
        chk("mid_we_mrg", {31'h0, mem_we2}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_we", {31'h0, mem_we2}, 32'h0);
        chk("mid_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("mid_rdata", resp_rdata, 32'h0);
        chk("mid_err", {31'h0, resp_err}, 32'h0);
        chk("mid_mem_address", {26'h0, mem_address}, 32'h0);
        chk("mid_wdata", mem_write_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_word", mem[2], 32'h11223344);
        do_req(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, lat, err, rd, we_cnt, we_cyc, we_addr);
        check_op("post_rst", 1'b0, 2'd2, 8'h08, 3, 1'b0, 32'h11223344,
                 lat, err, rd, we_cnt, we_cyc, we_addr);

        // Random requests against the reference model.
        for (int i = 0; i < 80; i++) begin
            we   = 1'($urandom);
            size = 2'($urandom_range(0, 3));
            uns  = 1'($urandom);
            addr = 8'($urandom_range(0, 31));
            wd   = $urandom;
            do_req(we, size, uns, addr, wd, lat, err, rd, we_cnt, we_cyc, we_addr);
            ref_access(we, size, uns, addr, wd, r_err, r_rd, r_lat);
            check_op($sformatf("rnd%0d", i), we, size, addr, r_lat, r_err, r_rd,
                     lat, err, rd, we_cnt, we_cyc, we_addr);
            chk($sformatf("rnd%0d_word", i), mem[addr[7:2]], ref_mem[addr[7:2]]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store unit between the CPU datapath and the word-organized data memory. Accepts one byte, halfword or word load/store per request handshake and drives the memory's word address, write data and write-enable. Turns sub-word stores into a read-modify-write and sign- or zero-extends sub-word loads. Returns one response pulse per accepted request.

## Interface
- `ADDR_W`, 6: memory word-address width; byte address is `ADDR_W+2` bits.
- `DATA_W`, 32: memory word width; fixed at 32 for byte/half lane logic.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W+2  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`: misaligned or illegal size.
- `mem_address`  out  ADDR_W  word address, `req_addr[ADDR_W+1:2]` as latched.
- `mem_write_data`  out  32  word to write.
- `mem_we2`  out  1  memory write-enable.
- `mem_read_data`  in  32  memory read port; registered, valid the cycle after an address is presented with `mem_we2`=0.

## Operation
- Little-endian: byte lane k = `addr[1:0]`, bits [8k+7:8k]; half lane = `addr[1]`, bits [16h+15:16h].
- A request is accepted on a rising edge with `req_valid && req_ready`. All request fields are latched then, and the inputs are don't-care afterwards.
- Error check at accept: size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0. The unit goes to RESP with `resp_err`=1 and `resp_rdata`=0, and does no memory access (`mem_we2` stays 0).
- States: IDLE, RD, CAP, MRG, WR, RESP.
- IDLE → WR on a word store, → RD on a load or sub-word store, → RESP on an error.
- RD: present address, `mem_we2`=0. RD → CAP for a load, → MRG for a sub-word store.
- CAP: select the lane from `mem_read_data`, extend it, register it into `resp_rdata`, then → RESP.
- MRG: replace only the addressed lane of `mem_read_data` with `req_wdata`. Register the merged word as the write data, keep `mem_we2`=0, then → WR.
- WR: `mem_we2`=1 for exactly one cycle with the write word, then → RESP.
- RESP: `resp_valid`=1 for one cycle, then → IDLE.
- `mem_address` holds the latched word address in every non-IDLE state. In IDLE it holds its last value; after reset it is 0.
- `mem_we2` is 1 only in WR.
- `resp_rdata` and `resp_err` hold their values until the next RESP.

## Timing
- Reset (async, `reset`=0): state IDLE. `req_ready`=1 once released; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_address`=0, `mem_write_data`=0, `mem_we2`=0 immediately.
- Reset mid-operation aborts the access. A store reset before WR leaves memory unmodified, and `mem_we2` drops without waiting for a clock.
- Accept at edge 0 gives this latency to `resp_valid` high:
  - word store: cycle 2 (WR in cycle 1)
  - load: cycle 3
  - sub-word store: cycle 4
  - error: cycle 1
- Next accept is possible in the cycle after RESP, i.e. throughput is one request per latency+1 cycles.
- `req_valid` high while `req_ready`=0 is ignored, not queued. The requester holds it until accepted.
- The unit issues at most one memory access per cycle and never reads and writes in the same cycle.

## Test plan
- Word round trip: store 0xDEADBEEF to byte addr 0x08, then load word from 0x08.
  - Required: `mem_we2` high exactly in cycle 1 with `mem_address`=2.
  - Load `resp_rdata`=0xDEADBEEF in cycle 3, `resp_err`=0.
- Sub-word store merge: memory word 2 = 0x11223344; store byte 0xAA to addr 0x09.
  - Required: WR writes 0x1122AA44.
  - Then store half 0x5566 to addr 0x0A; word reads 0x5566AA44.
- Load extension: word = 0x80FF7F01.
  - lb 0x0B signed → 0xFFFFFF80; lb 0x0B unsigned → 0x00000080.
  - lh 0x08 signed → 0x00007F01; lh 0x0A signed → 0xFFFF80FF.
- Errors: lw 0x09, lh 0x03, size 11 at 0x00.
  - Required: `resp_valid` in cycle 1 with `resp_err`=1 and `resp_rdata`=0.
  - `mem_we2` never asserted; memory contents unchanged.
- Handshake: hold `req_valid` high for back-to-back requests.
  - Required: `req_ready` low from cycle 1 until IDLE; the second request is accepted only then, and exactly one `resp_valid` per request.
- Reset mid-op: assert `reset`=0 during MRG of a byte store.
  - Required: `mem_we2` stays 0 and all outputs reach reset values without a clock edge.
  - After release, the first request behaves normally.
